// File: rtl/instruction_encoder.sv
// instruction_encoder: packs symbolic instructions into 32-bit IR words and streams them to instruction memory
module instruction_encoder #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [4:0]    mnem,
    input  logic [4:0]    dr,
    input  logic [4:0]    sa,
    input  logic [4:0]    sb,
    input  logic [14:0]   imm,
    output logic          imem_we,
    input  logic          imem_gnt,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err_illegal
);
    localparam int PW = $clog2(DEPTH);
    // field-use masks {dr, sa, sb, imm}
    localparam logic [3:0] F_R = 4'b1110, F_ST = 4'b0110, F_LD = 4'b1100;
    localparam logic [3:0] F_I = 4'b1101, F_B = 4'b0101, F_J = 4'b0100, F_N = 4'b0000;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
    state_t state_q, state_d;
    logic [31:0] mem_q [DEPTH];
    logic [PW:0] wptr_q, rptr_q;
    logic slot_v_q, err_q, done_q, done_d;
    logic [AW-1:0] addr_q;
    logic [31:0] data_q, enc;
    logic [6:0] op;
    logic [3:0] f;
    logic legal, full, empty, hs, push, pop, grant;

    // mnemonic table lookup: opcode plus which fields survive into the word
    always_comb begin
        op    = 7'b0;
        f     = F_N;
        legal = 1'b1;
        case (mnem)
            5'd0:  {op, f} = {7'b0000000, F_N};
            5'd1:  {op, f} = {7'b0000010, F_R};
            5'd2:  {op, f} = {7'b0000101, F_R};
            5'd3:  {op, f} = {7'b1100101, F_R};
            5'd4:  {op, f} = {7'b0001000, F_R};
            5'd5:  {op, f} = {7'b0001010, F_R};
            5'd6:  {op, f} = {7'b0001100, F_R};
            5'd7:  {op, f} = {7'b0000001, F_ST};
            5'd8:  {op, f} = {7'b0100001, F_LD};
            5'd9:  {op, f} = {7'b0100010, F_I};
            5'd10: {op, f} = {7'b0100101, F_I};
            5'd11: {op, f} = {7'b0101110, F_R};
            5'd12: {op, f} = {7'b0101000, F_I};
            5'd13: {op, f} = {7'b0101010, F_I};
            5'd14: {op, f} = {7'b0101100, F_I};
            5'd15: {op, f} = {7'b1100010, F_I};
            5'd16: {op, f} = {7'b1000000, F_R};
            5'd17: {op, f} = {7'b0110000, F_R};
            5'd18: {op, f} = {7'b0110001, F_R};
            5'd19: {op, f} = {7'b1100001, F_J};
            5'd20: {op, f} = {7'b0100000, F_B};
            5'd21: {op, f} = {7'b1100000, F_B};
            5'd22: {op, f} = {7'b1000100, F_B};
            5'd23: {op, f} = {7'b0000111, F_I};
            default: legal = 1'b0;
        endcase
    end

    assign enc = {op, f[3] ? dr : 5'd0, f[2] ? sa : 5'd0,
                  f[1] ? {sb, 10'd0} : (f[0] ? imm : 15'd0)};
    assign empty = wptr_q == rptr_q;
    assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign in_ready = (state_q == LOAD) && !full;
    assign hs    = in_valid && in_ready;
    assign push  = hs && legal;
    assign grant = slot_v_q && imem_gnt;
    assign pop   = !empty && (!slot_v_q || imem_gnt);
    assign imem_we     = slot_v_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = data_q;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign err_illegal = err_q;

    // session control: drain ends once both FIFO and output slot are empty
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = (hs && in_last) ? DRAIN : LOAD;
            DRAIN: begin
                state_d = (empty && !slot_v_q) ? IDLE : DRAIN;
                done_d  = empty && !slot_v_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, sticky error flag and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (state_q == IDLE && start) err_q <= 1'b0;
            else if (hs && !legal) err_q <= 1'b1;
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[PW-1:0]] <= enc;
    end

    // FIFO pointers, output slot and write address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            slot_v_q <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (pop) begin
                slot_v_q <= 1'b1;
                data_q   <= mem_q[rptr_q[PW-1:0]];
            end else if (imem_gnt) begin
                slot_v_q <= 1'b0;
            end
            if (state_q == IDLE && start) addr_q <= base_addr;
            else if (grant) addr_q <= addr_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed checks of packing, flow control, addressing and reset abort
module tb_instruction_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [4:0]  mnem = '0, dr = '0, sa = '0, sb = '0;
    logic [14:0] imm = '0;
    logic        imem_we;
    logic        imem_gnt = 1'b1;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy, done, err_illegal;
    int checks = 0;
    int fails = 0;
    logic [7:0]  wa[$];
    logic [31:0] wd[$];

    instruction_encoder #(.AW(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .mnem(mnem), .dr(dr), .sa(sa), .sb(sb), .imm(imm),
        .imem_we(imem_we), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // record every granted write, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && imem_we && imem_gnt) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic begin_session(input logic [7:0] b);
        wa.delete();
        wd.delete();
        start = 1'b1;
        base_addr = b;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] m, input logic [4:0] d, input logic [4:0] a,
                        input logic [4:0] b, input logic [14:0] i, input logic l);
        int n = 0;
        in_valid = 1'b1;
        {mnem, dr, sa, sb, imm, in_last} = {m, d, a, b, i, l};
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 60) begin
            step();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
        step();
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err_illegal}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // single ADD, exact latency and done timing
        begin_session(8'h10);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_ready", {31'd0, in_ready}, 32'd1);
        send(5'd1, 5'd3, 5'd1, 5'd2, 15'h1234, 1'b1);
        chk("t1_we_k", {31'd0, imem_we}, 32'd0);
        step();
        chk("t1_we_k1", {31'd0, imem_we}, 32'd1);
        chk("t1_addr", {24'd0, imem_addr}, 32'h10);
        chk("t1_data", imem_wdata, 32'h04308800);
        chk("t1_done_early", {31'd0, done}, 32'd0);
        step();
        chk("t1_we_off", {31'd0, imem_we}, 32'd0);
        chk("t1_done_k2", {31'd0, done}, 32'd0);
        step();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        step();
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_nwr", wa.size(), 32'd1);
        chk("t1_wa", {24'd0, wa[0]}, 32'h10);

        // formats with unused fields forced to zero
        begin_session(8'h20);
        send(5'd9, 5'd5, 5'd4, 5'd31, 15'd7, 1'b0);
        send(5'd20, 5'd9, 5'd2, 5'd17, 15'h7FFF, 1'b0);
        send(5'd7, 5'd7, 5'd3, 5'd4, 15'd1, 1'b0);
        send(5'd8, 5'd2, 5'd6, 5'd7, 15'h123, 1'b0);
        send(5'd19, 5'd3, 5'd5, 5'd9, 15'h55, 1'b1);
        wait_done("t2_done");
        chk("t2_nwr", wa.size(), 32'd5);
        chk("t2_adi", wd[0], 32'h44520007);
        chk("t2_bz", wd[1], 32'h40017FFF);
        chk("t2_st", wd[2], 32'h02019000);
        chk("t2_ld", wd[3], 32'h42230000);
        chk("t2_jmr", wd[4], 32'hC2028000);
        chk("t2_addr0", {24'd0, wa[0]}, 32'h20);
        chk("t2_addr4", {24'd0, wa[4]}, 32'h24);

        // illegal mnemonic between two NOPs
        begin_session(8'h40);
        send(5'd0, 5'd1, 5'd2, 5'd3, 15'h7FFF, 1'b0);
        send(5'd25, 5'd4, 5'd5, 5'd6, 15'h1, 1'b0);
        send(5'd0, 5'd31, 5'd31, 5'd31, 15'h7FFF, 1'b1);
        wait_done("t3_done");
        chk("t3_err", {31'd0, err_illegal}, 32'd1);
        chk("t3_nwr", wa.size(), 32'd2);
        chk("t3_a0", {24'd0, wa[0]}, 32'h40);
        chk("t3_a1", {24'd0, wa[1]}, 32'h41);
        chk("t3_d0", wd[0], 32'h0);
        chk("t3_d1", wd[1], 32'h0);

        // address wrap; new start clears the error
        begin_session(8'hFE);
        chk("t5_err_clr", {31'd0, err_illegal}, 32'd0);
        send(5'd2, 5'd1, 5'd2, 5'd3, 15'h7FFF, 1'b0);
        send(5'd4, 5'd4, 5'd5, 5'd6, 15'h0, 1'b0);
        send(5'd14, 5'd7, 5'd8, 5'd9, 15'h1234, 1'b1);
        wait_done("t5_done");
        chk("t5_nwr", wa.size(), 32'd3);
        chk("t5_a0", {24'd0, wa[0]}, 32'hFE);
        chk("t5_a1", {24'd0, wa[1]}, 32'hFF);
        chk("t5_a2", {24'd0, wa[2]}, 32'h00);
        chk("t5_sub", wd[0], 32'h0A110C00);
        chk("t5_and", wd[1], 32'h10429800);
        chk("t5_xri", wd[2], 32'h58741234);

        // illegal-only last instruction with empty FIFO
        begin_session(8'h30);
        send(5'd30, 5'd1, 5'd1, 5'd1, 15'h1, 1'b1);
        chk("t7_done_k", {31'd0, done}, 32'd0);
        step();
        chk("t7_done", {31'd0, done}, 32'd1);
        chk("t7_err", {31'd0, err_illegal}, 32'd1);
        chk("t7_nwr", wa.size(), 32'd0);

        // backpressure: gnt low, FIFO plus slot fill after DEPTH+1 accepts
        imem_gnt = 1'b0;
        begin_session(8'h80);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            {mnem, dr, sa, sb, imm, in_last} = {5'd16, 5'(i + 1), 5'd0, 5'd0, 15'h7FFF, 1'b0};
            chk("t4_ready", {31'd0, in_ready}, 32'd1);
            step();
        end
        {mnem, dr, in_last} = {5'd16, 5'd6, 1'b1};
        chk("t4_full", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_we", {31'd0, imem_we}, 32'd1);
            chk("t4_hold_addr", {24'd0, imem_addr}, 32'h80);
            chk("t4_hold_data", imem_wdata, 32'h80100000);
            step();
        end
        imem_gnt = 1'b1;
        send(5'd16, 5'd6, 5'd0, 5'd0, 15'h7FFF, 1'b1);
        wait_done("t4_done");
        chk("t4_nwr", wa.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("t4_addr", {24'd0, wa[i]}, 32'h80 + 32'(i));
            chk("t4_data", wd[i], {7'b1000000, 5'(i + 1), 20'd0});
        end

        // asynchronous reset mid-session with words buffered
        imem_gnt = 1'b0;
        begin_session(8'h60);
        send(5'd1, 5'd1, 5'd1, 5'd1, 15'h0, 1'b0);
        send(5'd1, 5'd2, 5'd2, 5'd2, 15'h0, 1'b0);
        send(5'd1, 5'd3, 5'd3, 5'd3, 15'h0, 1'b0);
        chk("t6_we_pre", {31'd0, imem_we}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_we", {31'd0, imem_we}, 32'd0);
        chk("t6_addr", {24'd0, imem_addr}, 32'd0);
        chk("t6_data", imem_wdata, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        imem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t6_no_done", {31'd0, done}, 32'd0);
            chk("t6_ready", {31'd0, in_ready}, 32'd0);
            chk("t6_we_after", {31'd0, imem_we}, 32'd0);
            step();
        end
        chk("t6_idle", {31'd0, busy}, 32'd0);
        chk("t6_nwr", wa.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
